uart_multirate_rx: RTL
======================

Name: uart_multirate_rx

Overview:
- Parametrised UART receiver with four run-time-selectable baud rates, configurable data width and optional parity.
- Adds start-bit glitch rejection, framing/parity/overrun error reporting, and an input synchroniser.
- Sits between the board RX pin and the command parser. Received words are held until the parser acknowledges them with clr.

Parameters:
CLOCK_FREQ, 100_000_000, system clock frequency in Hz
RATE0, 115200, baud rate selected when rate_sel=0
RATE1, 9600, baud rate selected when rate_sel=1
RATE2, 57600, baud rate selected when rate_sel=2
RATE3, 921600, baud rate selected when rate_sel=3
DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first
PARITY_MODE, 0, 0=none, 1=odd, 2=even
FIFO_DEPTH, 4, word FIFO depth (power of 2, >=2); used only with UART_RX_FIFO_EN

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
rx  input  1  serial line, idle high, asynchronous to clk
rate_sel  input  2  baud rate select
clr  input  1  acknowledge/pop the current word
data  output  DATA_BITS  received word
data_rec  output  1  word available
frame_err  output  1  stop bit of the presented word was 0
parity_err  output  1  parity mismatch on the presented word (always 0 when PARITY_MODE=0)
overrun  output  1  sticky: a word arrived while storage was full
rx_busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Divider: LIMITn = CLOCK_FREQ/RATEn (integer), HALFn = LIMITn/2. Counter width = clog2(max LIMITn + 1).
- rate_sel is latched on leaving IDLE. Changes mid-frame have no effect until the next frame.
- rx passes through a 2-FF synchroniser (rx_s), giving 2 cycles of latency. rx_s resets to 1.
- FSM states: IDLE, START, DATA, PARITY, STOP. The baud counter clears on every state entry.
- IDLE: rx_s==0 -> START.
- START: at count==HALF-1, sample rx_s.
  - rx_s==1: glitch, return to IDLE with no output.
  - rx_s==0: go to DATA.
- DATA: sample rx_s at each count==LIMIT-1 and shift right into the shift register. After DATA_BITS samples -> PARITY if PARITY_MODE!=0, else STOP.
- PARITY: sample at count==LIMIT-1 -> STOP.
  - Odd mode: error if XOR(data, parity bit) != 1.
  - Even mode: error if XOR(data, parity bit) != 0.
- STOP: sample at count==LIMIT-1, i.e. mid stop bit, then return to IDLE immediately. This allows back-to-back frames with a single stop bit.
- Completion: one cycle after the stop sample, a "word done" strobe fires.
  - The word is delivered even when it has a frame error; frame_err=~stop_bit.
  - The word, frame_err and parity_err are stored together.
- Reset values:
  - data = all ones
  - data_rec, frame_err, parity_err, overrun, rx_busy = 0
  - FSM in IDLE, latched rate = RATE0
- Reset asserted mid-frame aborts the frame with no output. Counters and the shift register clear.
- clr when data_rec==0 is ignored.
- A word completing in the same cycle as clr: the set wins, so data_rec stays 1.
- overrun clears only via reset, or via clr when storage is empty after the pop.

Optional Feature:
UART_RX_FIFO_EN
- Defined:
  - Words plus error flags enter a FIFO_DEPTH-deep FIFO.
  - data, frame_err and parity_err show the head entry; data_rec = not empty.
  - clr pops one entry. A simultaneous push and pop with a full FIFO is legal and loses nothing.
  - A push while full (no pop) drops the new word and sets overrun.
- Undefined:
  - Single holding register; clr clears data_rec.
  - A word completing while data_rec==1 and clr==0 overwrites the register and sets overrun.

Test Plan:
All scenarios use CLOCK_FREQ=1_000_000, RATE0=100_000 (LIMIT=10, HALF=5), RATE1=50_000 (LIMIT=20).
1. rate_sel=0, send 0xA5 with a good stop bit -> data=0xA5 and data_rec=1 one cycle after the stop-bit mid-sample; frame_err=0; clr -> data_rec=0.
2. rx low for 3 cycles, then high -> FSM returns to IDLE after HALF; data_rec stays 0; rx_busy pulses only.
3. rate_sel=1, send 0x3C, toggle rate_sel to 0 mid-frame -> 0x3C received correctly at 20 clk/bit.
4. PARITY_MODE=2, send 0x07 with parity bit 0 -> parity_err=1, data=0x07. Send 0x07 with stop bit 0 -> frame_err=1.
5. No FIFO: send 0x11 then 0x22 without clr -> data=0x22, overrun=1. With FIFO and depth 4: 5 words without clr -> first 4 read back in order, overrun=1.
6. Assert rst mid DATA -> all outputs at reset values; a subsequent 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_multirate_rx.sv
// ---------------------------------------------------------------------------
// uart_multirate_rx
//
// This block is a UART receiver that sits between the board RX pin and the
// command parser. It supports four baud rates that can be selected at run
// time. The data width and the parity mode are set by parameters. A start
// bit that does not stay low until its middle is treated as a glitch and
// ignored. The receiver reports framing, parity and overrun errors.
//
// Received words are held until the parser acknowledges them with clr.
//
// Build option:
//   UART_RX_FIFO_EN  When defined, each word and its error flags go into a
//                    FIFO that is FIFO_DEPTH deep. When not defined, a
//                    single holding register is used instead.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   rx          serial line; idles high and is asynchronous to clk
//   rate_sel    baud rate select; latched when a frame starts
//   clr         acknowledge/pop the word currently presented
//   data        received word, LSB received first
//   data_rec    a word is available
//   frame_err   the stop bit of the presented word was 0
//   parity_err  the presented word has a parity mismatch
//   overrun     sticky; a word arrived while storage was full
//   rx_busy     the receiver is inside a frame (the FSM is not IDLE)
// ---------------------------------------------------------------------------
module uart_multirate_rx #(
  parameter int unsigned CLOCK_FREQ  = 100_000_000,
  parameter int unsigned RATE0       = 115200,
  parameter int unsigned RATE1       = 9600,
  parameter int unsigned RATE2       = 57600,
  parameter int unsigned RATE3       = 921600,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [1:0]           rate_sel,
  input  logic                 clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_rec,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int unsigned LIMIT0 = CLOCK_FREQ / RATE0;
  localparam int unsigned LIMIT1 = CLOCK_FREQ / RATE1;
  localparam int unsigned LIMIT2 = CLOCK_FREQ / RATE2;
  localparam int unsigned LIMIT3 = CLOCK_FREQ / RATE3;
  localparam int unsigned MAX01  = (LIMIT0 > LIMIT1) ? LIMIT0 : LIMIT1;
  localparam int unsigned MAX23  = (LIMIT2 > LIMIT3) ? LIMIT2 : LIMIT3;
  localparam int unsigned MAX_LIMIT = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int unsigned CNT_W  = $clog2(MAX_LIMIT + 1);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_multirate_rx: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic                 rx_m, rx_s;
  logic [1:0]           rate_q;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     limit_m1, half_m1;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] sh;
  logic                 par_bit;
  logic                 par_calc;
  logic                 tick, latch_rate, shift_en, par_en, stop_en;
  logic                 done, done_fe, done_pe;

  // Two-flop synchroniser. It resets to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Per-rate terminal counts, selected by the rate latched for this frame.
  always_comb begin
    limit_m1 = CNT_W'(LIMIT0 - 1);
    half_m1  = CNT_W'(LIMIT0 / 2 - 1);
    case (rate_q)
      2'd1: begin
        limit_m1 = CNT_W'(LIMIT1 - 1);
        half_m1  = CNT_W'(LIMIT1 / 2 - 1);
      end
      2'd2: begin
        limit_m1 = CNT_W'(LIMIT2 - 1);
        half_m1  = CNT_W'(LIMIT2 / 2 - 1);
      end
      2'd3: begin
        limit_m1 = CNT_W'(LIMIT3 - 1);
        half_m1  = CNT_W'(LIMIT3 / 2 - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tick       = 1'b0;
    latch_rate = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt  = START;
          latch_rate = 1'b1;
        end
      end
      START: begin
        // Mid start bit: a line that is already high again was a glitch.
        if (cnt == half_m1) begin
          tick      = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == limit_m1) begin
          tick     = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT)
            state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (cnt == limit_m1) begin
          tick      = 1'b1;
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets a new start edge follow directly.
        if (cnt == limit_m1) begin
          tick      = 1'b1;
          stop_en   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

  always_comb begin
    par_calc = 1'b0;
    case (PARITY_MODE)
      1:       par_calc = ~(^sh ^ par_bit);
      2:       par_calc = ^sh ^ par_bit;
      default: par_calc = 1'b0;
    endcase
  end

  // Baud counter, bit counter, shift register and completion strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_q  <= 2'd0;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      par_bit <= 1'b0;
      done    <= 1'b0;
      done_fe <= 1'b0;
      done_pe <= 1'b0;
    end else begin
      if (latch_rate) rate_q <= rate_sel;

      if (tick || state_nxt != state) cnt <= '0;
      else if (state != IDLE)         cnt <= cnt + 1'b1;

      if (state != DATA) bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;

      if (shift_en) sh <= {rx_s, sh[DATA_BITS-1:1]};
      if (par_en)   par_bit <= rx_s;

      done <= stop_en;
      if (stop_en) begin
        done_fe <= ~rx_s;
        done_pe <= par_calc;
      end
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 full, empty, push, pop;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = clr && !empty;
  // When the FIFO is full, a pop in the same cycle frees the slot the push needs.
  assign push  = done && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= {2'b00, {DATA_BITS{1'b1}}};
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {done_pe, done_fe, sh};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (done && full && !pop)
        overrun <= 1'b1;
      else if (pop && !push && count == (AW+1)'(1))
        overrun <= 1'b0;
    end
  end

  assign {parity_err, frame_err, data} = mem[rd_ptr];
  assign data_rec = !empty;
`else
  logic [DATA_BITS-1:0] data_q;
  logic                 rec_q, fe_q, pe_q, ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '1;
      rec_q  <= 1'b0;
      fe_q   <= 1'b0;
      pe_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else if (done) begin
      // A new word beats a simultaneous acknowledge.
      data_q <= sh;
      fe_q   <= done_fe;
      pe_q   <= done_pe;
      rec_q  <= 1'b1;
      if (rec_q && !clr) ovr_q <= 1'b1;
    end else if (clr && rec_q) begin
      rec_q <= 1'b0;
      ovr_q <= 1'b0;
    end
  end

  assign data       = data_q;
  assign data_rec   = rec_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign overrun    = ovr_q;
`endif

endmodule
